dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the core's D_MEM port: word-organised RAM with byte/half/word lane access.
//  Sits outside the core on the DMEM stage.
//  Reads are registered, with 1-cycle latency, so read data is valid in WB.
//  On reset, a sequencer zero-fills the array. A checker flags and counts illegal accesses.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words; power of two, >=2
//  ADDR_WIDTH   32             byte-address width
//  WORD_WIDTH   32             data width; fixed at 32
//  MMIO_ADDR    32'hFFFF_FFF0  word-aligned store-only MMIO address (DMEM_MMIO_EN only)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           synchronous reset, active-high
//  addr         in   ADDR_WIDTH  byte address
//  dataIn       in   WORD_WIDTH  store data, LSB-justified
//  memRead      in   1           load request
//  memWrite     in   1           store request
//  memMode      in   2           00 byte, 01 half, 10 word, 11 reserved
//  dataOut      out  WORD_WIDTH  registered load data
//  ready        out  1           high once init has completed
//  misalignErr  out  1           1-cycle pulse on a rejected access
//  errCount     out  16          saturating count of rejected accesses
//  mmioValid    out  1           1-cycle pulse on an MMIO store (DMEM_MMIO_EN)
//  mmioData     out  WORD_WIDTH  last MMIO store data (DMEM_MMIO_EN)
// BEHAVIOUR
//  Reset: state=INIT, initPtr=0, dataOut=0, ready=0, misalignErr=0, errCount=0, mmioValid=0, mmioData=0.
//    Reset asserted mid-INIT or mid-RUN restarts INIT from word 0.
//  FSM INIT:
//    - Each cycle writes 0 to word initPtr, then initPtr++.
//    - After the cycle that writes word DEPTH_WORDS-1, next state is RUN and ready=1 from that edge.
//    - Init therefore takes exactly DEPTH_WORDS cycles after rst deasserts.
//    - All requests are ignored during INIT: no write, dataOut held, no error, not counted.
//  FSM RUN: terminal until rst.
//  Indexing:
//    - word = addr[2 +: $clog2(DEPTH_WORDS)]; upper address bits are ignored (aliasing).
//    - lane = addr[1:0].
//  Legality:
//    - byte accesses are always legal.
//    - half requires addr[0]=0.
//    - word requires addr[1:0]=0.
//    - mode 11 is illegal.
//    - memRead&&memWrite in the same cycle is illegal.
//  Illegal access (RUN):
//    - No array update and dataOut held.
//    - misalignErr=1 for the cycle after the request edge.
//    - errCount += 1, saturating at 16'hFFFF.
//  Store (legal, RUN):
//    - Byte enables at the edge: byte -> 1<<lane, half -> 2'b11<<lane, word -> 4'hF.
//    - Data: byte dataIn[7:0] and half dataIn[15:0], replicated onto the enabled lanes.
//  Load (legal, RUN):
//    - dataOut updates at the request edge with the lane-extracted value.
//    - Byte/half are sign-extended to 32 bits; word is passed through.
//    - dataOut holds until the next legal load; it is not cleared by idle cycles or stores.
//  Read-after-write: a load in the cycle after a store to the same word returns the new data.
//  misalignErr and mmioValid are registered pulses, never asserted during INIT.
// CONFIGURATION
//  DMEM_MMIO_EN defined:
//    - A legal word store with addr==MMIO_ADDR updates mmioData and pulses mmioValid for 1 cycle.
//    - That store does NOT update the array.
//    - Loads from MMIO_ADDR read the array (aliased word).
//    - Non-word or misaligned stores to the MMIO word follow the normal legality and array rules.
//  DMEM_MMIO_EN undefined:
//    - mmioValid is tied to 0 and mmioData to 0.
//    - MMIO_ADDR is treated as an ordinary aliased array address.
// TESTING
//  1 DEPTH_WORDS=16; deassert rst; store at cycle 3 -> ignored; ready rises exactly 16 cycles after rst drop; load word 0 -> 0.
//  2 Store byte 0x80 @0x5, load byte @0x5 -> 0xFFFFFF80.
//    Then load word @0x4 -> 0x00008000.
//  3 Store word 0x1234_5678 @0x8 then immediate load half @0xA -> 0x00001234 on next cycle.
//  4 Load half @0x3 -> misalignErr pulse, errCount 0->1, dataOut unchanged.
//    Then read+write together @0x0 -> errCount=2, word 0 unchanged.
//  5 Force errCount=16'hFFFE; issue 3 illegal accesses -> errCount=16'hFFFF, 3 misalignErr pulses.
//  6 DMEM_MMIO_EN: store 0xCAFE_0001 @MMIO_ADDR -> mmioValid 1 cycle, mmioData=0xCAFE_0001, aliased word unchanged.
//    Assert rst mid-INIT -> outputs at reset values, and a full re-init.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word lanes, registered loads,
// zero-fill on reset and an illegal-access checker. Optional MMIO store port: DMEM_MMIO_EN.
module dmem_responder #(
    parameter int                    DEPTH_WORDS = 1024,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    WORD_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] dataIn,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            memMode,
    output logic [WORD_WIDTH-1:0] dataOut,
    output logic                  ready,
    output logic                  misalignErr,
    output logic [15:0]           errCount,
    output logic                  mmioValid,
    output logic [WORD_WIDTH-1:0] mmioData
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      init_ptr_q, init_ptr_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
    logic                  err_q, err_d;
    logic [15:0]           err_count_q, err_count_d;
    logic                  mmio_valid_q, mmio_valid_d;
    logic [WORD_WIDTH-1:0] mmio_data_q, mmio_data_d;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [3:0]            mem_be;
    logic [WORD_WIDTH-1:0] mem_wdata;

    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            lane;
    logic                  req, illegal, is_mmio;
    logic [WORD_WIDTH-1:0] rd_shift, ld_val, st_data;
    logic [3:0]            st_be;
    logic                  unused_bits;

    assign word_idx    = addr[2 +: IDX_W];
    assign lane        = addr[1:0];
    assign req         = memRead || memWrite;
    assign unused_bits = ^{addr, MMIO_ADDR};

    always_comb begin
        illegal = 1'b0;
        if (memRead && memWrite) illegal = 1'b1;
        case (memMode)
            2'b00:   ;
            2'b01:   if (addr[0]) illegal = 1'b1;
            2'b10:   if (lane != 2'b00) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

`ifdef DMEM_MMIO_EN
    assign is_mmio = memWrite && (memMode == 2'b10) && (addr == MMIO_ADDR);
`else
    assign is_mmio = 1'b0;
`endif

    // Lane extraction: shift the addressed byte/half down to bit 0, then sign-extend.
    assign rd_shift = mem_q[word_idx] >> {lane, 3'b000};

    always_comb begin
        ld_val  = mem_q[word_idx];
        st_be   = 4'hF;
        st_data = dataIn;
        case (memMode)
            2'b00: begin
                ld_val  = {{24{rd_shift[7]}}, rd_shift[7:0]};
                st_be   = 4'b0001 << lane;
                st_data = {4{dataIn[7:0]}};
            end
            2'b01: begin
                ld_val  = {{16{rd_shift[15]}}, rd_shift[15:0]};
                st_be   = 4'b0011 << lane;
                st_data = {2{dataIn[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        data_out_d   = data_out_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        mmio_valid_d = 1'b0;
        mmio_data_d  = mmio_data_q;
        mem_we       = 1'b0;
        mem_idx      = word_idx;
        mem_be       = 4'h0;
        mem_wdata    = '0;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_idx    = init_ptr_q;
                mem_be     = 4'hF;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_RUN;
            end
            default: begin
                if (req && illegal) begin
                    err_d = 1'b1;
                    if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                end else if (memWrite) begin
                    if (is_mmio) begin
                        mmio_valid_d = 1'b1;
                        mmio_data_d  = dataIn;
                    end else begin
                        mem_we    = 1'b1;
                        mem_be    = st_be;
                        mem_wdata = st_data;
                    end
                end else if (memRead) begin
                    data_out_d = ld_val;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            data_out_q   <= '0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            mmio_valid_q <= 1'b0;
            mmio_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            data_out_q   <= data_out_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            mmio_valid_q <= mmio_valid_d;
            mmio_data_q  <= mmio_data_d;
        end
    end

    // Array has no reset; the INIT sweep zero-fills it once rst drops.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign dataOut     = data_out_q;
    assign ready       = (state_q == ST_RUN);
    assign misalignErr = err_q;
    assign errCount    = err_count_q;
`ifdef DMEM_MMIO_EN
    assign mmioValid   = mmio_valid_q;
    assign mmioData    = mmio_data_q;
`else
    assign mmioValid   = 1'b0;
    assign mmioData    = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model predicts each
// cycle's outputs; a monitor compares them against the DUT after every edge.
module tb_dmem_responder;
    localparam int          DEPTH = 16;
    localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, dataIn = '0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [1:0]  memMode = 2'b00;
    logic [31:0] dataOut, mmioData;
    logic        ready, misalignErr, mmioValid;
    logic [15:0] errCount;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .WORD_WIDTH(32), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .rst(rst), .addr(addr), .dataIn(dataIn), .memRead(memRead),
        .memWrite(memWrite), .memMode(memMode), .dataOut(dataOut), .ready(ready),
        .misalignErr(misalignErr), .errCount(errCount), .mmioValid(mmioValid),
        .mmioData(mmioData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic        rdy;
        logic        err;
        logic [15:0] cnt;
        logic        mv;
        logic [31:0] md;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [7:0]  mref [DEPTH*4];
    int          m_init;
    logic [31:0] m_dout, m_md;
    logic        m_err, m_mv;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic rd, input logic wr, input logic [1:0] md,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          nb, base;
        logic [31:0] v;
        bit          bad;
        @(negedge clk);
        rst = r; memRead = rd; memWrite = wr; memMode = md; addr = a; dataIn = d;
        m_err = 1'b0;
        m_mv  = 1'b0;
        if (r) begin
            m_init = 0; m_dout = '0; m_cnt = '0; m_md = '0;
            for (int i = 0; i < DEPTH*4; i++) mref[i] = 8'h00;
        end else if (m_init < DEPTH) begin
            m_init++;
        end else if (rd || wr) begin
            nb   = (md == 2'd3) ? 0 : (1 << md);
            base = int'(a % (DEPTH*4));
            bad  = (rd && wr) || (md == 2'd3) || (md == 2'd1 && a % 2 != 0) ||
                   (md == 2'd2 && a % 4 != 0);
            if (bad) begin
                m_err = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end else if (wr) begin
`ifdef DMEM_MMIO_EN
                if (md == 2'd2 && a == MMIO) begin
                    m_mv = 1'b1;
                    m_md = d;
                end else
`endif
                for (int i = 0; i < nb; i++) mref[base+i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (32'(mref[base+i]) << (8*i));
                if (nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (nb == 2 && v[15]) v = v | 32'hFFFF_0000;
                m_dout = v;
            end
        end
        e.dout = m_dout; e.rdy = (m_init >= DEPTH); e.err = m_err;
        e.cnt = m_cnt; e.mv = m_mv; e.md = m_md;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("dataOut", dataOut, mon_e.dout);
            chk("ready", 32'(ready), 32'(mon_e.rdy));
            chk("misalignErr", 32'(misalignErr), 32'(mon_e.err));
            chk("errCount", 32'(errCount), 32'(mon_e.cnt));
            chk("mmioValid", 32'(mmioValid), 32'(mon_e.mv));
            chk("mmioData", mmioData, mon_e.md);
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  md;
        int          op;
        m_init = 0; m_dout = '0; m_cnt = '0; m_md = '0; m_err = 1'b0; m_mv = 1'b0;
        for (int i = 0; i < DEPTH*4; i++) mref[i] = 8'h00;

        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        // INIT: a store on the third cycle must be ignored; ready after 16 edges
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'hDEAD_BEEF);
        idle(DEPTH - 3);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);

        cycle(1'b0, 1'b0, 1'b1, 2'b00, 32'h5, 32'h0000_0080);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'h5, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h4, 32'h0);

        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'h8, 32'h1234_5678);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'hA, 32'h0);

        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h3, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        idle(1);

        // Saturation: preload the counter just below its ceiling
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        #1 release dut.err_count_q;
        m_cnt = 16'hFFFE;
        cycle(1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 2'b11, 32'h4, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h6, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 2'b01, 32'h1, 32'h0);
        idle(1);

        cycle(1'b0, 1'b0, 1'b1, 2'b10, MMIO, 32'hCAFE_0001);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, MMIO, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 2'b01, MMIO, 32'h0000_BEEF);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, MMIO, 32'h0);

        for (int n = 0; n < 400; n++) begin
            a  = $urandom;
            d  = $urandom;
            md = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (md == 2'd1) a[0] = 1'b0;
                if (md == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) begin
                a  = MMIO;
                md = 2'd2;
            end
            op = $urandom_range(0, 9);
            cycle(1'b0, op >= 4 && op <= 8, op <= 3 || op == 8, md, a, d);
        end

        // Reset mid-INIT restarts the sweep from word 0
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        idle(5);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        idle(DEPTH);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h8, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'h5, 32'h0);
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
